// File: rtl/multi_clock_divider.sv
// Runtime-programmable multi-channel clock divider with per-channel enable and period ticks.
// Divisor writes are staged and only adopted at a period start, so no period is ever cut short.
module multi_clock_divider #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 16
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic cfg_valid;
  logic cfg_ack_q, cfg_err_q;

  assign cfg_valid = cfg_wr && (32'(cfg_ch) < NUM_CH) && (cfg_div >= DIV_W'(2));

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_valid;
      cfg_err_q <= cfg_wr && !cfg_valid;
    end
  end

  assign cfg_ack = cfg_ack_q;
  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic [DIV_W-1:0] p_q, p_d;
    logic [DIV_W-1:0] p_next, d_eff, high_len;
    logic             pend_v_q, pend_v_d;
    logic             run_q, run_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrap, wr_hit;

    assign wr_hit = cfg_valid && (cfg_ch == 4'(i));
    // div is always >= 2, so div-1 never underflows and p+1 never overflows.
    assign wrap     = (p_q == div_q - DIV_W'(1));
    assign p_next   = wrap ? '0 : p_q + DIV_W'(1);
    assign d_eff    = (wrap && pend_v_q) ? pend_div_q : div_q;
    assign high_len = d_eff - (d_eff >> 1);

    always_comb begin
      div_d      = div_q;
      pend_div_d = pend_div_q;
      pend_v_d   = pend_v_q;
      p_d        = p_q;
      run_d      = run_q;
      clk_d      = 1'b0;
      tick_d     = 1'b0;
      if (!ch_en[i]) begin
        run_d = 1'b0;
        p_d   = '0;
      end else if (!run_q || sync_restart) begin
        run_d  = 1'b1;
        p_d    = '0;
        clk_d  = 1'b1;
        tick_d = 1'b1;
        if (pend_v_q) begin
          div_d    = pend_div_q;
          pend_v_d = 1'b0;
        end
      end else begin
        p_d    = p_next;
        clk_d  = (p_next < high_len);
        tick_d = wrap;
        if (wrap && pend_v_q) begin
          div_d    = pend_div_q;
          pend_v_d = 1'b0;
        end
      end
      // Applied after the boundary logic so a same-edge write waits for the next boundary.
      if (wr_hit) begin
        pend_div_d = cfg_div;
        pend_v_d   = 1'b1;
      end
    end

    always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
        div_q      <= DIV_W'(DEFAULT_DIV);
        pend_div_q <= DIV_W'(DEFAULT_DIV);
        pend_v_q   <= 1'b0;
        p_q        <= '0;
        run_q      <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        div_q      <= div_d;
        pend_div_q <= pend_div_d;
        pend_v_q   <= pend_v_d;
        p_q        <= p_d;
        run_q      <= run_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised, runtime-programmable successor to the fixed 50 MHz→3.125 MHz divider. It produces NUM_CH independent divided clocks plus per-channel period-start ticks from clk_50M. Each channel has its own enable and a divisor that can be reprogrammed without glitches. It feeds the PWM, UART-baud and sensor-sampling blocks of the robot controller.

## Interface
Parameters:
- NUM_CH, 4, number of output channels (1–16)
- DIV_W, 16, divisor width in bits
- DEFAULT_DIV, 16, reset divisor for every channel (16 gives 3.125 MHz from 50 MHz); must be ≥ 2

Ports:
- clk_50M  in  1  system clock; all logic on its rising edge
- rst_n  in  1  synchronous, active-low reset
- ch_en  in  NUM_CH  per-channel run enable, level-sensitive
- sync_restart  in  1  one-cycle strobe; phase-aligns all enabled channels
- cfg_wr  in  1  divisor write strobe
- cfg_ch  in  4  target channel index
- cfg_div  in  DIV_W  new divisor D
- cfg_ack  out  1  one-cycle pulse: write accepted
- cfg_err  out  1  one-cycle pulse: write rejected
- clk_out  out  NUM_CH  divided clocks, registered
- tick  out  NUM_CH  one-cycle pulse at each clk_out rising edge, registered

## Operation
- Per-channel state:
  - `div` (active D, DIV_W bits)
  - `pend_div` plus `pend_v` (pending write)
  - phase counter `p` (DIV_W bits)
  - `run` flag
- High time is H = D − (D>>1), i.e. ceil(D/2). Examples: D=16 gives 8 high / 8 low; D=3 gives 2 high / 1 low.
- Per-channel priority, evaluated every edge:
  1. rst_n=0: reset (see Timing).
  2. ch_en[i]=0: run←0, p←0, clk_out[i]←0, tick[i]←0. The pending divisor stays pending.
  3. Start. Condition: ch_en[i]=1 and (run=0 or sync_restart=1). Action:
     - run←1, p←0, clk_out[i]←1, tick[i]←1
     - if pend_v: div←pend_div, pend_v←0
  4. Running. Action: p_next = (p==div−1) ? 0 : p+1, and p←p_next.
     - If p_next==0 and pend_v: div←pend_div, pend_v←0, and use the new D for this period's H.
     - clk_out[i]←(p_next < H), tick[i]←(p_next==0).
- Divisor changes take effect only at a period start, so no truncated or stretched periods occur.
- Config write, sampled when cfg_wr=1:
  - Valid only if cfg_ch < NUM_CH and cfg_div ≥ 2.
  - Valid write: pend_div[cfg_ch]←cfg_div, pend_v←1, cfg_ack pulses.
  - Invalid write: no state change, cfg_err pulses.
  - A second write before the boundary overwrites the pending value (last write wins).
- A write sampled on the same edge as a channel boundary is applied at the following boundary, not the current one.
- Channels are fully independent except for sync_restart.

## Timing
- Reset values (rst_n low at an edge): clk_out=0, tick=0, cfg_ack=0, cfg_err=0, all div=DEFAULT_DIV, pend_v=0, p=0, run=0.
- Reset asserted mid-period drops every output to 0 on that edge; pending writes are discarded.
- Enable latency: ch_en[i] first sampled high at edge k gives clk_out[i]=1 and tick[i]=1 from edge k onward. tick falls at edge k+1.
- Steady state: clk_out period is exactly D cycles. tick is high exactly 1 of every D cycles, coincident with the clk_out rising edge.
- cfg_ack/cfg_err: high for exactly the one cycle after the sampling edge. Back-to-back writes give back-to-back pulses.
- sync_restart at edge k: every enabled channel shows tick=1 and clk_out=1 after edge k, regardless of its previous phase. Disabled channels are unaffected.
- Disable mid-high: clk_out drops on the sampling edge, giving a shortened final high pulse. This is permitted; downstream logic must use tick.
- Wrap-around: D = 2^DIV_W−1 is legal. The p==div−1 comparison must not overflow.

## Test plan
- Reset, then ch_en=4'b0001 with default D=16:
  - clk_out[0] shows 8 high / 8 low, period 16.
  - tick[0] pulses every 16 cycles.
  - Channels 1–3 stay 0.
- Write cfg_ch=0, cfg_div=5 mid-period:
  - cfg_ack pulses once.
  - The current 16-cycle period completes intact.
  - Next periods are 5 cycles: 3 high / 2 low.
- Write cfg_div=1, then a write with cfg_ch=5 on NUM_CH=4:
  - cfg_err pulses for each write.
  - cfg_ack stays 0.
  - Divisors are unchanged.
- Channels 0 and 1 running D=16 and D=10 at different phases; pulse sync_restart:
  - Both ticks fire on the same cycle.
  - Ch0 next ticks at +16, ch1 at +10.
- Write D=7 then D=9 to ch2 within one period: the next period is 9 cycles; 7 is never observed.
- Drop rst_n mid-period:
  - All outputs are 0 the next cycle.
  - After release with ch_en held, the channel restarts at DEFAULT_DIV=16.
